pic_inta_sequencer: RTL



---
 rtl/pic_pkg.sv | 19 +
 rtl/sync_2ff.sv | 31 +++
 rtl/pic_inta_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// pic_pkg
// Shared definitions for the 8259 PIC integration blocks.
//   inta_state_t : states of the CPU-side interrupt acknowledge sequencer
//   INTA_CNT_W   : width of the sequencer's pulse/gap down-counter
`timescale 1ns/1ps
package pic_pkg;

    localparam int INTA_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE1  = 3'd1,
        GAP     = 3'd2,
        PULSE2  = 3'd3,
        VALID   = 3'd4,
        RECOVER = 3'd5
    } inta_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear on reset so the synchronized output starts low.
//   clock : destination clock
//   reset : synchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : input synchronized to clock (two-cycle latency)
`timescale 1ns/1ps
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
// CPU-side 8086-style interrupt acknowledge sequencer for the 8259 PIC.
// Synchronizes INT, issues two active-low INTA pulses, captures the vector
// byte the PIC drives during the second pulse and offers it to the CPU model
// on a valid/ready handshake.
//   clock                   : system clock
//   reset                   : synchronous active-high reset
//   interrupt_to_cpu        : INT from the PIC (asynchronous)
//   int_enable              : CPU interrupt flag, looked at only in IDLE
//   data_bus_in             : PIC data bus as seen by the CPU
//   interrupt_acknowledge_n : INTA to the PIC, active low, registered
//   vector                  : captured interrupt vector
//   vector_valid            : vector holds a byte not yet accepted
//   vector_ready            : consumer accepts vector
//   busy                    : sequencer is not in IDLE
`timescale 1ns/1ps
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_to_cpu,
    input  logic       int_enable,
    input  logic [7:0] data_bus_in,
    output logic       interrupt_acknowledge_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       busy
);

    localparam logic [INTA_CNT_W-1:0] PULSE_LD = INTA_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [INTA_CNT_W-1:0] GAP_LD   = INTA_CNT_W'(GAP_CYCLES - 1);

    logic                  int_sync;
    inta_state_t           state_q;
    logic [INTA_CNT_W-1:0] cnt_q;
    logic                  inta_n_q;
    logic [7:0]            vector_q;
    logic                  vector_valid_q;

    sync_2ff u_int_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (interrupt_to_cpu),
        .q_o   (int_sync)
    );

    // INTA and vector_valid are updated on the same edge as the state change
    // they belong to, so they are plain flop outputs with no decode glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            inta_n_q       <= 1'b1;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (int_sync && int_enable) begin
                        state_q  <= PULSE1;
                        cnt_q    <= PULSE_LD;
                        inta_n_q <= 1'b0;
                    end
                end
                PULSE1: begin
                    if (cnt_q == '0) begin
                        state_q  <= GAP;
                        cnt_q    <= GAP_LD;
                        inta_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q  <= PULSE2;
                        cnt_q    <= PULSE_LD;
                        inta_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE2: begin
                    // Bus is sampled on the last edge of pulse 2; the PIC has
                    // had the whole pulse to drive it.
                    if (cnt_q == '0) begin
                        state_q        <= VALID;
                        vector_q       <= data_bus_in;
                        vector_valid_q <= 1'b1;
                        inta_n_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                VALID: begin
                    if (vector_ready) begin
                        state_q        <= RECOVER;
                        cnt_q          <= GAP_LD;
                        vector_valid_q <= 1'b0;
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    cnt_q          <= '0;
                    inta_n_q       <= 1'b1;
                    vector_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign vector                  = vector_q;
    assign vector_valid            = vector_valid_q;
    assign busy                    = (state_q != IDLE);

endmodule
